disp_page_arbiter: RTL and testbench

Time-shares the 16-character hex dot-matrix display among up to four requesters (central FSM status, audio debug, sensor debug, alerts). It selects one page at a time by round-robin with fixed dwell, lets urgent pages preempt, and generates the blink phase. It drives the `data`/`blank_data`/`blink_data` inputs of the 16-hex display driver and sits between the central FSM and that driver.

---
 rtl/disp_page_arbiter_pkg.sv | 28 ++
 rtl/disp_page_arbiter_rr_pick.sv | 27 ++
 rtl/disp_page_arbiter.sv | 155 +++++++++++++++
 tb/tb_disp_page_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/disp_page_arbiter_pkg.sv
// Shared types and constants for the display page arbiter.
// Holds the FSM state encoding, page geometry and the priority helper.
package disp_page_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_URGENT = 2'd2
  } arb_state_e;

  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;
  localparam int PAGE_W = 64;
  localparam int MASK_W = 16;

  localparam logic [MASK_W-1:0] BLANK_ALL = 16'hFFFF;

  // Lowest set index wins; returns 0 for an empty vector (callers gate on |v).
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_page_arbiter_rr_pick.sv
// Round-robin search: first set request after 'last', wrapping, with 'last' itself tried last.
module rr_pick
  import disp_page_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] next
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest match wins.
  always_comb begin
    valid = 1'b0;
    next  = last;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (req[cand]) begin
        valid = 1'b1;
        next  = cand;
      end
    end
  end

endmodule

// File: rtl/disp_page_arbiter.sv
// Time-shares the 16-digit hex display among four page requesters with
// round-robin dwell rotation, urgent preemption and a blink phase generator.
module disp_page_arbiter
  import disp_page_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DWELL_CYCLES = 27_000_000,
  parameter int BLINK_HALF   = 6_750_000
) (
  input  logic                    clock_27mhz,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        urgent,
  input  logic                    hold,
  input  logic [N_REQ*PAGE_W-1:0] page_data,
  input  logic [N_REQ*MASK_W-1:0] page_blank,
  input  logic [N_REQ*MASK_W-1:0] page_blink,
  output logic [PAGE_W-1:0]       data_out,
  output logic [MASK_W-1:0]       blank_out,
  output logic [MASK_W-1:0]       blink_out,
  output logic [N_REQ-1:0]        grant,
  output logic                    switch_pulse
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [DW-1:0]    dwell_cnt, dwell_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [BW-1:0]    blink_cnt;
  logic             phase;

  logic [N_REQ-1:0] urg;
  logic             any_urg;
  logic [IDX_W-1:0] urg_idx;
  logic             rr_valid;
  logic [IDX_W-1:0] rr_next;

  assign urg     = urgent & req;
  assign any_urg = |urg;
  assign urg_idx = lowest_idx(urg);

  // ptr always holds the current or most recent owner, so one search serves every path.
  rr_pick u_rr_pick (
    .req   (req),
    .last  (ptr),
    .valid (rr_valid),
    .next  (rr_next)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    dwell_nxt = dwell_cnt;
    case (state)
      ST_IDLE: begin
        dwell_nxt = '0;
        if (any_urg) begin
          state_nxt = ST_URGENT;
          ptr_nxt   = urg_idx;
        end else if (rr_valid) begin
          state_nxt = ST_ROTATE;
          ptr_nxt   = rr_next;
        end
      end
      ST_ROTATE: begin
        if (any_urg) begin
          state_nxt = ST_URGENT;
          ptr_nxt   = urg_idx;
          dwell_nxt = '0;
        end else if (!req[ptr]) begin
          dwell_nxt = '0;
          if (rr_valid) ptr_nxt = rr_next;
          else          state_nxt = ST_IDLE;
        end else if (!hold) begin
          if (dwell_cnt == DWELL_LAST) begin
            ptr_nxt   = rr_next;
            dwell_nxt = '0;
          end else begin
            dwell_nxt = dwell_cnt + DW'(1);
          end
        end
      end
      ST_URGENT: begin
        dwell_nxt = '0;
        if (any_urg) begin
          ptr_nxt = urg_idx;
        end else if (rr_valid) begin
          state_nxt = ST_ROTATE;
          ptr_nxt   = rr_next;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        dwell_nxt = '0;
      end
    endcase

    grant_nxt = '0;
    if (state_nxt != ST_IDLE) grant_nxt[ptr_nxt] = 1'b1;
  end

  always_ff @(posedge clock_27mhz or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      ptr          <= IDX_W'(N_REQ - 1);
      dwell_cnt    <= '0;
      grant        <= '0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      dwell_cnt    <= dwell_nxt;
      grant        <= grant_nxt;
      switch_pulse <= (grant_nxt != grant);
    end
  end

  // Blink phase: free-running, independent of ownership.
  always_ff @(posedge clock_27mhz or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Output stage: page fields of the registered owner, one cycle behind grant.
  always_ff @(posedge clock_27mhz or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      blank_out <= BLANK_ALL;
      blink_out <= '0;
    end else if (grant == '0) begin
      data_out  <= '0;
      blank_out <= BLANK_ALL;
      blink_out <= '0;
    end else begin
      data_out  <= page_data[int'(ptr)*PAGE_W +: PAGE_W];
      blank_out <= page_blank[int'(ptr)*MASK_W +: MASK_W];
      blink_out <= page_blink[int'(ptr)*MASK_W +: MASK_W] & {MASK_W{phase}};
    end
  end

endmodule

// File: tb/tb_disp_page_arbiter.sv
// Randomized bench for disp_page_arbiter against a behavioural arbitration model.
module tb_disp_page_arbiter;

  localparam int DWELL = 8;
  localparam int BH    = 3;
  localparam int M_IDLE = 0, M_ROT = 1, M_URG = 2;

  logic         clock_27mhz = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = '0, urgent = '0;
  logic         hold = 1'b0;
  logic [255:0] page_data = '0;
  logic [63:0]  page_blank = '0, page_blink = '0;
  logic [63:0]  data_out;
  logic [15:0]  blank_out, blink_out;
  logic [3:0]   grant;
  logic         switch_pulse;

  disp_page_arbiter #(.N_REQ(4), .DWELL_CYCLES(DWELL), .BLINK_HALF(BH)) dut (
    .clock_27mhz (clock_27mhz),
    .reset       (reset),
    .req         (req),
    .urgent      (urgent),
    .hold        (hold),
    .page_data   (page_data),
    .page_blank  (page_blank),
    .page_blink  (page_blink),
    .data_out    (data_out),
    .blank_out   (blank_out),
    .blink_out   (blink_out),
    .grant       (grant),
    .switch_pulse(switch_pulse)
  );

  always #5 clock_27mhz = ~clock_27mhz;

  int n_tests = 0;
  int n_fail  = 0;
  bit fix_blink = 1'b0;

  // reference model state
  int          m_mode, m_owner, m_dwell, m_edges;
  logic [3:0]  m_grant;
  logic        m_pulse, m_phase;
  logic [63:0] e_data;
  logic [15:0] e_blank, e_blink;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_from(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_owner = 3; m_dwell = 0; m_edges = 0;
    m_grant = '0; m_pulse = 1'b0; m_phase = 1'b0;
    e_data = '0; e_blank = 16'hFFFF; e_blink = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [3:0] ur, g_new;
    int p;
    if (m_grant == '0) begin
      e_data = '0; e_blank = 16'hFFFF; e_blink = '0;
    end else begin
      e_data  = page_data[m_owner*64 +: 64];
      e_blank = page_blank[m_owner*16 +: 16];
      e_blink = page_blink[m_owner*16 +: 16] & {16{m_phase}};
    end
    ur = urgent & req;
    if (ur != 0) begin
      m_mode = M_URG; m_owner = lowest(ur); m_dwell = 0;
    end else if (m_mode == M_IDLE) begin
      if (req != 0) begin m_mode = M_ROT; m_owner = rr_from(req, m_owner); m_dwell = 0; end
    end else if (m_mode == M_URG || !req[m_owner]) begin
      p = rr_from(req, m_owner);
      if (p < 0) m_mode = M_IDLE;
      else begin m_mode = M_ROT; m_owner = p; end
      m_dwell = 0;
    end else if (!hold) begin
      if (m_dwell == DWELL - 1) begin m_owner = rr_from(req, m_owner); m_dwell = 0; end
      else m_dwell++;
    end
    g_new = (m_mode == M_IDLE) ? 4'b0 : 4'(1 << m_owner);
    m_pulse = (g_new != m_grant);
    m_grant = g_new;
    m_edges++;
    m_phase = ((m_edges / BH) % 2) == 1;
  endtask

  task automatic check_outputs();
    chk("grant", 64'(grant), 64'(m_grant));
    chk("switch_pulse", 64'(switch_pulse), 64'(m_pulse));
    chk("data_out", data_out, e_data);
    chk("blank_out", 64'(blank_out), 64'(e_blank));
    chk("blink_out", 64'(blink_out), 64'(e_blink));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'h0);
    chk({tag, "_pulse"}, 64'(switch_pulse), 64'h0);
    chk({tag, "_data"}, data_out, 64'h0);
    chk({tag, "_blank"}, 64'(blank_out), 64'hFFFF);
    chk({tag, "_blink"}, 64'(blink_out), 64'h0);
  endtask

  // Called at a negedge: drive inputs, advance the model, check at the next negedge.
  task automatic step(input logic [3:0] r, input logic [3:0] u, input logic h);
    req = r; urgent = u; hold = h;
    for (int i = 0; i < 8; i++) page_data[i*32 +: 32] = $urandom;
    page_blank = {$urandom, $urandom};
    page_blink = fix_blink ? {4{16'h000F}} : {$urandom, $urandom};
    model_edge();
    @(negedge clock_27mhz);
    check_outputs();
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_reset_values(tag);
    @(negedge clock_27mhz);
    reset = 1'b0;
    model_reset();
  endtask

  logic [3:0] cur_r, cur_u;

  initial begin
    model_reset();
    repeat (2) @(negedge clock_27mhz);
    check_reset_values("por");
    reset = 1'b0;

    repeat (5) step(4'b0000, 4'b0000, 1'b0);
    repeat (40) step(4'b0101, 4'b0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if (m_grant == 4'b0010 && m_dwell == 3) break;
      step(4'b0111, 4'b0000, 1'b0);
    end
    repeat (20) step(4'b0101, 4'b0000, 1'b0);

    for (int i = 0; i < 20; i++) begin
      if (m_grant == 4'b0001) break;
      step(4'b0001, 4'b0000, 1'b0);
    end
    repeat (3) step(4'b1001, 4'b0000, 1'b0);
    repeat (12) step(4'b1001, 4'b1000, 1'b0);
    repeat (20) step(4'b1001, 4'b0000, 1'b0);

    repeat (3) step(4'b0011, 4'b0000, 1'b0);
    repeat (20) step(4'b0011, 4'b0000, 1'b1);
    repeat (20) step(4'b0011, 4'b0000, 1'b0);

    fix_blink = 1'b1;
    repeat (11) step(4'b0001, 4'b0000, 1'b0);
    async_reset("mid_blink");
    repeat (10) step(4'b0001, 4'b0000, 1'b0);
    fix_blink = 1'b0;

    cur_r = 4'b0110; cur_u = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) cur_r = 4'($urandom_range(15));
      if ($urandom_range(19) == 0) cur_u = ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'b0;
      step(cur_r, cur_u, $urandom_range(9) == 0);
      if (i == 750) async_reset("rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
